axi_rd_resp_model: RTL and testbench

AXI_RD_RESP_MODEL -- requirements
Module: axi_rd_resp_model

---
 rtl/axi_rd_resp_model.sv | 170 +++++++++++++++++
 tb/tb_axi_rd_resp_model.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_resp_model.sv
// AXI read-response model: in-order AR queue, latency-gated R bursts with address-pattern data.
// Optional SLVERR region for addresses >= ERR_BASE when AXI_RD_RESP_ERR_EN is defined.
module axi_rd_resp_model #(
  parameter int          D_WIDTH   = 64,
  parameter int          ID_WIDTH  = 3,
  parameter int          LEN_WIDTH = 4,
  parameter int          DEPTH     = 4,
  parameter int          LATENCY   = 4,
  parameter logic [31:0] ERR_BASE  = 32'hFFFF_0000
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       arvalid,
  output logic                       arready,
  input  logic [31:0]                araddr,
  input  logic [LEN_WIDTH-1:0]       arlen,
  input  logic [ID_WIDTH-1:0]        arid,
  output logic                       rvalid,
  input  logic                       rready,
  output logic [D_WIDTH-1:0]         rdata,
  output logic [ID_WIDTH-1:0]        rid,
  output logic [1:0]                 rresp,
  output logic                       rlast,
  output logic [$clog2(DEPTH):0]     outstanding
);

  localparam int LANES = D_WIDTH / 32;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;

  typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

  state_t state, state_next;

  logic [15:0]          ts_cnt;
  logic [29:0]          fifo_word [DEPTH];
  logic [LEN_WIDTH-1:0] fifo_len  [DEPTH];
  logic [ID_WIDTH-1:0]  fifo_id   [DEPTH];
  logic [15:0]          fifo_ts   [DEPTH];
  logic                 fifo_err  [DEPTH];

  logic [AW-1:0]        wr_ptr, rd_ptr, nxt_ptr, launch_ptr;
  logic [CW-1:0]        count, count_next;
  logic                 push, xfer, pop, launch;
  logic                 head_ok, nxt_ok, acc_err, unused_bits;
  logic [15:0]          head_age, nxt_age;
  logic [31:0]          cur_word;
  logic [LEN_WIDTH-1:0] beat, len_q;
  logic                 err_q;

`ifdef AXI_RD_RESP_ERR_EN
  assign acc_err     = (araddr >= ERR_BASE);
  assign unused_bits = ^araddr[1:0];
`else
  assign acc_err     = 1'b0;
  assign unused_bits = ^{ERR_BASE, araddr[1:0]};
`endif

  assign rvalid      = (state == BURST);
  assign outstanding = count;
  assign push        = arvalid && arready;
  assign xfer        = rvalid && rready;
  assign pop         = xfer && rlast;
  assign nxt_ptr     = rd_ptr + 1'b1;
  assign count_next  = count + CW'(push) - CW'(pop);

  // Ages are modulo 2^16 so eligibility survives timestamp counter wrap.
  assign head_age = ts_cnt - fifo_ts[rd_ptr];
  assign nxt_age  = ts_cnt - fifo_ts[nxt_ptr];
  assign head_ok  = (count != '0) && (head_age >= 16'(LATENCY));
  assign nxt_ok   = (count > CW'(1)) && (nxt_age >= 16'(LATENCY));

  function automatic logic [D_WIDTH-1:0] lane_data(input logic [31:0] word, input logic err);
    logic [D_WIDTH-1:0] d;
    d = '0;
    if (!err) begin
      for (int i = 0; i < LANES; i++) d[i*32 +: 32] = word + 32'(i);
    end
    return d;
  endfunction

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_next;
  end

  // A launch loads beat 0 of an entry; after an rlast the follower launches in the same edge.
  always_comb begin
    state_next = state;
    launch     = 1'b0;
    launch_ptr = rd_ptr;
    case (state)
      IDLE, WAIT: begin
        if (head_ok) begin
          state_next = BURST;
          launch     = 1'b1;
        end else if (count != '0) begin
          state_next = WAIT;
        end
      end
      BURST: begin
        if (pop) begin
          if (nxt_ok) begin
            launch     = 1'b1;
            launch_ptr = nxt_ptr;
          end else if ((count > CW'(1)) || push) begin
            state_next = WAIT;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (push) begin
      fifo_word[wr_ptr] <= araddr[31:2];
      fifo_len[wr_ptr]  <= arlen;
      fifo_id[wr_ptr]   <= arid;
      fifo_ts[wr_ptr]   <= ts_cnt;
      fifo_err[wr_ptr]  <= acc_err;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ts_cnt   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      arready  <= 1'b0;
      rdata    <= '0;
      rid      <= '0;
      rresp    <= 2'b00;
      rlast    <= 1'b0;
      cur_word <= '0;
      beat     <= '0;
      len_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      ts_cnt  <= ts_cnt + 16'd1;
      count   <= count_next;
      arready <= (count_next != CW'(DEPTH));
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= nxt_ptr;
      if (launch) begin
        cur_word <= {2'b00, fifo_word[launch_ptr]};
        beat     <= '0;
        len_q    <= fifo_len[launch_ptr];
        err_q    <= fifo_err[launch_ptr];
        rid      <= fifo_id[launch_ptr];
        rlast    <= (fifo_len[launch_ptr] == '0);
        rresp    <= fifo_err[launch_ptr] ? 2'b10 : 2'b00;
        rdata    <= lane_data({2'b00, fifo_word[launch_ptr]}, fifo_err[launch_ptr]);
      end else if (pop) begin
        rlast <= 1'b0;
        rresp <= 2'b00;
        rdata <= '0;
      end else if (xfer) begin
        cur_word <= cur_word + 32'(LANES);
        beat     <= beat + 1'b1;
        rlast    <= ((beat + 1'b1) == len_q);
        rdata    <= lane_data(cur_word + 32'(LANES), err_q);
      end
    end
  end

endmodule

// File: tb/tb_axi_rd_resp_model.sv
// Bench for axi_rd_resp_model: queue-based reference model checked every cycle plus directed literals.
// Honours AXI_RD_RESP_ERR_EN the same way as the design.
module tb_axi_rd_resp_model;

  localparam int          D_WIDTH   = 64;
  localparam int          ID_WIDTH  = 3;
  localparam int          LEN_WIDTH = 4;
  localparam int          DEPTH     = 4;
  localparam int          LATENCY   = 4;
  localparam logic [31:0] ERR_BASE  = 32'hFFFF_0000;
  localparam int          LANES     = D_WIDTH / 32;

  logic                 aclk = 1'b0;
  logic                 aresetn = 1'b1;
  logic                 arvalid = 1'b0;
  logic                 arready;
  logic [31:0]          araddr = '0;
  logic [LEN_WIDTH-1:0] arlen = '0;
  logic [ID_WIDTH-1:0]  arid = '0;
  logic                 rvalid;
  logic                 rready = 1'b0;
  logic [D_WIDTH-1:0]   rdata;
  logic [ID_WIDTH-1:0]  rid;
  logic [1:0]           rresp;
  logic                 rlast;
  logic [$clog2(DEPTH):0] outstanding;

  axi_rd_resp_model #(
    .D_WIDTH(D_WIDTH), .ID_WIDTH(ID_WIDTH), .LEN_WIDTH(LEN_WIDTH),
    .DEPTH(DEPTH), .LATENCY(LATENCY), .ERR_BASE(ERR_BASE)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .arvalid(arvalid), .arready(arready),
    .araddr(araddr), .arlen(arlen), .arid(arid), .rvalid(rvalid), .rready(rready),
    .rdata(rdata), .rid(rid), .rresp(rresp), .rlast(rlast), .outstanding(outstanding)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [31:0] addr;
    int          len;
    int          id;
    int          accept;
    int          beat;
  } req_t;

  req_t mq[$];
  int   compared = 0;
  int   mismatched = 0;
  int   cyc = 0;
  int   edgesSinceRst = 0;
  int   freeFrom = 0;
  int   lastRlastEdge = 0;
  int   acceptEdge = 0;
  logic prevStall = 1'b0;
  logic [D_WIDTH-1:0] prevData;
  logic [ID_WIDTH-1:0] prevId;
  logic prevLast;
  logic [1:0] prevResp;

  always @(posedge aclk) cyc++;

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) edgesSinceRst = 0;
    else          edgesSinceRst++;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeoutFail(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: actual=timeout required=event (cycle %0d)", name, cyc);
  endtask

  function automatic logic [D_WIDTH-1:0] expData(input logic [31:0] addr, input int k);
    logic [31:0] word;
    logic [D_WIDTH-1:0] d;
    word = {2'b00, addr[31:2]};
    d = '0;
`ifdef AXI_RD_RESP_ERR_EN
    if (addr >= ERR_BASE) return d;
`endif
    for (int i = 0; i < LANES; i++) d[i*32 +: 32] = word + 32'(k * LANES + i);
    return d;
  endfunction

  function automatic logic [1:0] expResp(input logic [31:0] addr);
`ifdef AXI_RD_RESP_ERR_EN
    if (addr >= ERR_BASE) return 2'b10;
`endif
    return 2'b00;
  endfunction

  // Reference: a head request may be presented once it is LATENCY edges old and the previous burst is gone.
  always @(negedge aclk) begin
    logic expRvalid;
    if (!aresetn) begin
      mq.delete();
      freeFrom = 0;
      prevStall = 1'b0;
    end else begin
      expRvalid = 1'b0;
      if (mq.size() > 0) expRvalid = (cyc >= mq[0].accept + LATENCY) && (cyc >= freeFrom);
      checkOutput("rvalid", 64'(rvalid), 64'(expRvalid));
      checkOutput("outstanding", 64'(outstanding), 64'(mq.size()));
      checkOutput("arready", 64'(arready), 64'((edgesSinceRst > 0) && (mq.size() < DEPTH)));
      if (prevStall) begin
        checkOutput("stall_rdata", 64'(rdata), 64'(prevData));
        checkOutput("stall_rid", 64'(rid), 64'(prevId));
        checkOutput("stall_rlast", 64'(rlast), 64'(prevLast));
        checkOutput("stall_rresp", 64'(rresp), 64'(prevResp));
      end
      if (expRvalid) begin
        checkOutput("rdata", 64'(rdata), 64'(expData(mq[0].addr, mq[0].beat)));
        checkOutput("rid", 64'(rid), 64'(mq[0].id));
        checkOutput("rresp", 64'(rresp), 64'(expResp(mq[0].addr)));
        checkOutput("rlast", 64'(rlast), 64'(mq[0].beat == mq[0].len));
        if (rready) begin
          mq[0].beat = mq[0].beat + 1;
          if (mq[0].beat > mq[0].len) begin
            mq.pop_front();
            freeFrom = cyc + 1;
            lastRlastEdge = cyc + 1;
          end
        end
      end
      if (arvalid && arready)
        mq.push_back('{addr: araddr, len: int'(arlen), id: int'(arid), accept: cyc + 1, beat: 0});
      prevStall = rvalid && !rready;
      prevData = rdata;
      prevId = rid;
      prevLast = rlast;
      prevResp = rresp;
    end
  end

  // Called just after a rising edge; returns just after the handshake edge.
  task automatic applyStimulus(input logic [31:0] addr, input int len, input int id);
    int budget = 300;
    araddr  = addr;
    arlen   = LEN_WIDTH'(len);
    arid    = ID_WIDTH'(id);
    arvalid = 1'b1;
    do begin
      @(negedge aclk);
      budget--;
    end while (!arready && budget > 0);
    if (!arready) timeoutFail("ar_handshake");
    @(posedge aclk);
    #1;
    arvalid = 1'b0;
    acceptEdge = cyc;
  endtask

  task automatic waitRvalid();
    int budget = 200;
    do begin
      @(negedge aclk);
      budget--;
    end while (!rvalid && budget > 0);
    if (!rvalid) timeoutFail("wait_rvalid");
  endtask

  task automatic drain();
    int budget = 300;
    rready = 1'b1;
    do begin
      @(negedge aclk);
      budget--;
    end while ((outstanding != '0 || rvalid) && budget > 0);
    if (outstanding != '0 || rvalid) timeoutFail("drain");
    @(posedge aclk);
    #1;
  endtask

  task automatic toNegedge(input int target);
    do @(negedge aclk); while (cyc < target);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=running required=finished (cycle %0d)", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] t1Data [4];
    logic [63:0] stallData;
    int n, tStart, budget;
    t1Data = '{64'h00000041_00000040, 64'h00000043_00000042,
               64'h00000045_00000044, 64'h00000047_00000046};

    // Reset values and arready release.
    #1 aresetn = 1'b0;
    #2;
    checkOutput("rst_rvalid", 64'(rvalid), 64'd0);
    checkOutput("rst_arready", 64'(arready), 64'd0);
    checkOutput("rst_outstanding", 64'(outstanding), 64'd0);
    checkOutput("rst_rdata", 64'(rdata), 64'd0);
    checkOutput("rst_rlast", 64'(rlast), 64'd0);
    #19 aresetn = 1'b1;
    #1 checkOutput("rst_arready_held", 64'(arready), 64'd0);
    @(posedge aclk);
    #1 checkOutput("rst_arready_rise", 64'(arready), 64'd1);

    // Single burst: first beat LATENCY edges after the handshake.
    rready = 1'b1;
    applyStimulus(32'h100, 3, 5);
    n = acceptEdge;
    toNegedge(n + 3);
    checkOutput("t1_rvalid_early", 64'(rvalid), 64'd0);
    toNegedge(n + 4);
    checkOutput("t1_rvalid_first", 64'(rvalid), 64'd1);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge aclk);
      checkOutput("t1_rdata", 64'(rdata), t1Data[k]);
      checkOutput("t1_rid", 64'(rid), 64'd5);
      checkOutput("t1_rlast", 64'(rlast), 64'(k == 3));
    end
    drain();

    // Queue fills at DEPTH; fifth request waits for the first rlast.
    rready = 1'b0;
    tStart = cyc;
    for (int i = 0; i < 4; i++) applyStimulus(32'h1000 + 32'(i * 16), 1, i);
    @(negedge aclk);
    checkOutput("t2_full_arready", 64'(arready), 64'd0);
    checkOutput("t2_full_outstanding", 64'(outstanding), 64'd4);
    @(posedge aclk);
    #1;
    fork
      applyStimulus(32'h2000, 1, 4);
      begin
        repeat (5) begin
          @(negedge aclk);
          checkOutput("t2_blocked", 64'(arready), 64'd0);
        end
        @(posedge aclk);
        #1 rready = 1'b1;
      end
    join
    checkOutput("t2_accept_after_rlast", 64'((lastRlastEdge > tStart) && (acceptEdge > lastRlastEdge)), 64'd1);
    drain();

    // rready 1-0-0-1 mid-burst.
    rready = 1'b1;
    applyStimulus(32'h300, 3, 6);
    waitRvalid();
    @(posedge aclk);
    #1 rready = 1'b0;
    @(negedge aclk);
    stallData = rdata;
    checkOutput("t3_stall_a", 64'(rdata), 64'h000000C3_000000C2);
    @(negedge aclk);
    checkOutput("t3_stall_b", 64'(rdata), stallData);
    @(posedge aclk);
    #1 rready = 1'b1;
    @(negedge aclk);
    @(negedge aclk);
    checkOutput("t3_resume", 64'(rdata), 64'h000000C5_000000C4);
    drain();

    // Two eligible queued bursts run back to back.
    rready = 1'b0;
    applyStimulus(32'h500, 1, 1);
    applyStimulus(32'h600, 1, 2);
    repeat (8) @(posedge aclk);
    #1 rready = 1'b1;
    budget = 100;
    do begin
      @(negedge aclk);
      budget--;
    end while (!(rvalid && rlast && rid == 3'd1) && budget > 0);
    if (!(rvalid && rlast && rid == 3'd1)) timeoutFail("t4_first_rlast");
    @(negedge aclk);
    checkOutput("t4_b2b_rvalid", 64'(rvalid), 64'd1);
    checkOutput("t4_b2b_rid", 64'(rid), 64'd2);
    checkOutput("t4_b2b_rdata", 64'(rdata), 64'h00000181_00000180);
    drain();

    // Asynchronous reset during beat 2, then a fresh request.
    rready = 1'b1;
    applyStimulus(32'h400, 3, 7);
    waitRvalid();
    @(negedge aclk);
    @(negedge aclk);
    #2 aresetn = 1'b0;
    #1;
    checkOutput("t5_rvalid", 64'(rvalid), 64'd0);
    checkOutput("t5_rdata", 64'(rdata), 64'd0);
    checkOutput("t5_rid", 64'(rid), 64'd0);
    checkOutput("t5_rlast", 64'(rlast), 64'd0);
    checkOutput("t5_rresp", 64'(rresp), 64'd0);
    checkOutput("t5_outstanding", 64'(outstanding), 64'd0);
    checkOutput("t5_arready", 64'(arready), 64'd0);
    repeat (2) @(posedge aclk);
    #3 aresetn = 1'b1;
    @(posedge aclk);
    #1;
    applyStimulus(32'h200, 0, 3);
    waitRvalid();
    checkOutput("t5_fresh_rdata", 64'(rdata), 64'h00000081_00000080);
    checkOutput("t5_fresh_rid", 64'(rid), 64'd3);
    checkOutput("t5_fresh_rlast", 64'(rlast), 64'd1);
    drain();

    // Address at ERR_BASE.
    rready = 1'b1;
    applyStimulus(32'hFFFF_0000, 1, 4);
    waitRvalid();
`ifdef AXI_RD_RESP_ERR_EN
    checkOutput("t6_resp0", 64'(rresp), 64'd2);
    checkOutput("t6_data0", 64'(rdata), 64'd0);
    @(negedge aclk);
    checkOutput("t6_resp1", 64'(rresp), 64'd2);
    checkOutput("t6_data1", 64'(rdata), 64'd0);
`else
    checkOutput("t6_resp0", 64'(rresp), 64'd0);
    checkOutput("t6_data0", 64'(rdata), 64'h3FFFC001_3FFFC000);
    @(negedge aclk);
    checkOutput("t6_resp1", 64'(rresp), 64'd0);
    checkOutput("t6_data1", 64'(rdata), 64'h3FFFC003_3FFFC002);
`endif
    checkOutput("t6_rlast1", 64'(rlast), 64'd1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
